// File: rtl/imem_arbiter.sv
// Round-robin arbiter between IF and LS for the shared synchronous-read instruction ROM.
// Misaligned LS requests are answered with an error response without touching the ROM.
module imem_arbiter #(
  parameter int unsigned ROM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              ls_req_i,
  input  logic [31:0]       ls_addr_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic              ls_err_o,
  output logic [31:0]       ls_rdata_o,
  output logic              rom_en_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i
);

  typedef enum logic {GntIf, GntLs} gnt_e;

  gnt_e        last_q, last_d;
  logic        if_eff, ls_aligned, ls_eff, ls_mis;
  logic        if_win, ls_win;
  logic        resp_if_q, resp_ls_q, resp_err_q;
  logic [31:0] if_hold_q, ls_hold_q;
  logic        unused_addr;

  // Upper address bits are dropped on purpose so addresses wrap modulo the ROM size.
  assign unused_addr = ^{if_addr_i[31:ROM_AW+2], if_addr_i[1:0], ls_addr_i[31:ROM_AW+2]};

  always_comb begin
    if_eff     = if_req_i & ~if_flush_i;
    ls_aligned = (ls_addr_i[1:0] == 2'b00);
    ls_eff     = ls_req_i & ls_aligned;
    ls_mis     = ls_req_i & ~ls_aligned;
    // On a tie the port that did not win last time gets the slot.
    if_win     = if_eff & (~ls_eff | (last_q == GntLs));
    ls_win     = ls_eff & (~if_eff | (last_q == GntIf));

    last_d = last_q;
    if (if_win) begin
      last_d = GntIf;
    end else if (ls_win) begin
      last_d = GntLs;
    end

    if_gnt_o   = if_win;
    ls_gnt_o   = ls_win | ls_mis;
    rom_en_o   = if_win | ls_win;
    rom_addr_o = '0;
    if (if_win) begin
      rom_addr_o = if_addr_i[ROM_AW+1:2];
    end else if (ls_win) begin
      rom_addr_o = ls_addr_i[ROM_AW+1:2];
    end

    if_rvalid_o = resp_if_q & ~if_flush_i;
    if_rdata_o  = if_rvalid_o ? rom_data_i : if_hold_q;
    ls_rvalid_o = resp_ls_q;
    ls_err_o    = resp_ls_q & resp_err_q;
    if (!resp_ls_q) begin
      ls_rdata_o = ls_hold_q;
    end else if (resp_err_q) begin
      ls_rdata_o = '0;
    end else begin
      ls_rdata_o = rom_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= GntLs;
      resp_if_q  <= 1'b0;
      resp_ls_q  <= 1'b0;
      resp_err_q <= 1'b0;
      if_hold_q  <= '0;
      ls_hold_q  <= '0;
    end else begin
      last_q     <= last_d;
      resp_if_q  <= if_win;
      resp_ls_q  <= ls_gnt_o;
      resp_err_q <= ls_mis;
      if (if_rvalid_o) begin
        if_hold_q <= if_rdata_o;
      end
      if (ls_rvalid_o) begin
        ls_hold_q <= ls_rdata_o;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised scoreboard bench for imem_arbiter against a behavioural ROM and arbitration model.
module tb_imem_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned WORDS = 1 << AW;

  typedef struct {
    logic          gif;
    logic          gls;
    logic          en;
    logic [AW-1:0] addr;
  } gnt_t;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0, if_flush = 1'b0, ls_req = 1'b0;
  logic [31:0]   if_addr = '0, ls_addr = '0;
  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, rom_en;
  logic [31:0]   if_rdata, ls_rdata, rom_q;
  logic [AW-1:0] rom_addr;

  logic [31:0] mem [WORDS];
  gnt_t        gq[$];
  resp_t       ifq[$];
  resp_t       lsq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        last_if;              // model: previous ROM grant went to IF
  logic [31:0] if_hold_m, ls_hold_m;

  imem_arbiter #(.ROM_AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_flush_i (if_flush),
    .if_gnt_o   (if_gnt),
    .if_rvalid_o(if_rvalid),
    .if_rdata_o (if_rdata),
    .ls_req_i   (ls_req),
    .ls_addr_i  (ls_addr),
    .ls_gnt_o   (ls_gnt),
    .ls_rvalid_o(ls_rvalid),
    .ls_err_o   (ls_err),
    .ls_rdata_o (ls_rdata),
    .rom_en_o   (rom_en),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_en) rom_q <= mem[rom_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Model of one request cycle; pushes expected grants and responses.
  task automatic model_cycle(output logic gif, output logic gls);
    logic ife, lsa, lsm, win_if, win_ls;
    gnt_t g;
    resp_t r;
    ife = if_req && !if_flush;
    lsa = ls_req && (ls_addr % 4 == 0);
    lsm = ls_req && (ls_addr % 4 != 0);
    win_if = ife && (!lsa || !last_if);
    win_ls = lsa && !win_if;
    if (win_if) last_if = 1'b1;
    else if (win_ls) last_if = 1'b0;
    g.gif = win_if;
    g.gls = win_ls || lsm;
    g.en = win_if || win_ls;
    g.addr = win_if ? AW'((if_addr / 4) % WORDS) : AW'((ls_addr / 4) % WORDS);
    gq.push_back(g);
    if (win_if) begin
      r.due = cyc + 1; r.err = 1'b0; r.data = mem[(if_addr / 4) % WORDS];
      ifq.push_back(r);
    end
    if (win_ls || lsm) begin
      r.due = cyc + 1; r.err = lsm; r.data = lsm ? 32'h0 : mem[(ls_addr / 4) % WORDS];
      lsq.push_back(r);
    end
    gif = win_if;
    gls = g.gls;
  endtask

  task automatic reset_model();
    gq.delete(); ifq.delete(); lsq.delete();
    last_if = 1'b0; if_hold_m = '0; ls_hold_m = '0;
  endtask

  task automatic run_random(input int n);
    logic gif, gls, pend_if, pend_ls;
    pend_if = 1'b0; pend_ls = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if_flush = ($urandom_range(0, 5) == 0);
      if (!pend_if) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = {$urandom_range(0, 7) == 0 ? 20'($urandom) : 20'h0, 10'($urandom), 2'b00};
      end
      if (!pend_ls) begin
        ls_req  = ($urandom_range(0, 2) != 0);
        ls_addr = {20'($urandom), 10'($urandom_range(0, 15)),
                   $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b00};
      end
      model_cycle(gif, gls);
      // A denied requester keeps its request stable; a flushed one may redirect.
      pend_if = if_req && !if_flush && !gif;
      pend_ls = ls_req && !gls;
    end
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0;
    model_cycle(gif, gls);
  endtask

  // Monitor: pops expectations and compares whenever the DUT is out of reset.
  always @(negedge clk) begin
    if (rst) begin
      logic exp_v;
      resp_t e;
      if (gq.size() > 0) begin
        gnt_t g;
        g = gq.pop_front();
        chk("if_gnt", 32'(if_gnt), 32'(g.gif));
        chk("ls_gnt", 32'(ls_gnt), 32'(g.gls));
        chk("rom_en", 32'(rom_en), 32'(g.en));
        if (g.en) chk("rom_addr", 32'(rom_addr), 32'(g.addr));
      end
      exp_v = 1'b0;
      e = '{due: 0, err: 1'b0, data: 32'h0};
      if (ifq.size() > 0 && ifq[0].due == cyc) begin
        e = ifq.pop_front();
        exp_v = !if_flush;
      end
      chk("if_rvalid", 32'(if_rvalid), 32'(exp_v));
      if (exp_v) if_hold_m = e.data;
      chk("if_rdata", if_rdata, if_hold_m);
      exp_v = 1'b0;
      if (lsq.size() > 0 && lsq[0].due == cyc) begin
        e = lsq.pop_front();
        exp_v = 1'b1;
      end
      chk("ls_rvalid", 32'(ls_rvalid), 32'(exp_v));
      chk("ls_err", 32'(ls_err), 32'(exp_v && e.err));
      if (exp_v) ls_hold_m = e.data;
      chk("ls_rdata", ls_rdata, ls_hold_m);
    end
  end

  initial begin
    logic gif, gls;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    rom_q = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 32'h0);
    chk("rst_rom_en", 32'(rom_en), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_rvalid", 32'({if_rvalid, ls_rvalid, ls_err}), 32'h0);
    chk("rst_rdata", if_rdata | ls_rdata, 32'h0);
    rst = 1'b1;

    run_random(400);

    // Reset right after a grant drops the in-flight response.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10; if_flush = 1'b0; ls_req = 1'b1; ls_addr = 32'h8;
    model_cycle(gif, gls);
    @(posedge clk); #1;
    rst = 1'b0;
    if_req = 1'b0; ls_req = 1'b0;
    #1;
    chk("mid_rst_if_rvalid", 32'(if_rvalid), 32'h0);
    chk("mid_rst_ls_rvalid", 32'(ls_rvalid), 32'h0);
    chk("mid_rst_if_rdata", if_rdata, 32'h0);
    reset_model();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      model_cycle(gif, gls);
    end
    // Tie straight after reset: IF must win.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h1004; ls_req = 1'b1; ls_addr = 32'h8;
    model_cycle(gif, gls);

    run_random(300);
    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", 32'(gq.size() + ifq.size() + lsq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
